// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file scoreboard.
// Holds default widths/counts and a clog2 helper for key width.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: write bypass, key-0 masking, stale-busy flag.
// Ports: reset, key, stored/stored_busy, qualified writes A/B, value/busy.
module regfile_read_port #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            reset,
  input  logic [AW-1:0]   key,
  input  logic [XLEN-1:0] stored,
  input  logic            stored_busy,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_key,
  input  logic [XLEN-1:0] wa_value,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_key,
  input  logic [XLEN-1:0] wb_value,
  output logic [XLEN-1:0] value,
  output logic            busy
);

  logic hit_a;
  logic hit_b;
  logic zero;

  // wa_en/wb_en arrive already qualified: nonzero key,
  // and B dropped when it collides with A.
  always_comb begin
    zero  = reset || (key == '0);
    hit_a = wa_en && (wa_key == key);
    hit_b = wb_en && (wb_key == key);
    if (zero)       value = '0;
    else if (hit_a) value = wa_value;
    else if (hit_b) value = wb_value;
    else            value = stored;
    busy = !zero && stored_busy && !hit_a && !hit_b;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two write ports, N read ports and a busy scoreboard.
// Ports: clk, reset, rd_key/rd_value/rd_busy, wa_*, wb_*, iss_*, busy_count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NREAD = NREAD_DEF,
  localparam int AW    = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_key,
  output logic [NREAD*XLEN-1:0] rd_value,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wa_en,
  input  logic [AW-1:0]         wa_key,
  input  logic [XLEN-1:0]       wa_value,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_key,
  input  logic [XLEN-1:0]       wb_value,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_key,
  output logic [AW:0]           busy_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wa_ok;
  logic             wb_ok;
  logic             iss_ok;
  logic             inc;
  logic [1:0]       dec;

  // An issue overrides a same-cycle write clear: the
  // new producer supersedes the one just retired.
  always_comb begin
    wa_ok  = wa_en && (wa_key != '0);
    wb_ok  = wb_en && (wb_key != '0)
             && !(wa_ok && (wa_key == wb_key));
    iss_ok = iss_en && (iss_key != '0);
    busy_nxt = busy;
    if (wa_ok)  busy_nxt[wa_key]  = 1'b0;
    if (wb_ok)  busy_nxt[wb_key]  = 1'b0;
    if (iss_ok) busy_nxt[iss_key] = 1'b1;
    inc = iss_ok && !busy[iss_key];
    dec = 2'(wa_ok && busy[wa_key]
             && !(iss_ok && (iss_key == wa_key)))
        + 2'(wb_ok && busy[wb_key]
             && !(iss_ok && (iss_key == wb_key)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wa_ok) regs[wa_key] <= wa_value;
      if (wb_ok) regs[wb_key] <= wb_value;
      busy       <= busy_nxt;
      busy_count <= busy_count + (AW+1)'(inc)
                    - (AW+1)'(dec);
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] k;
    assign k = rd_key[i*AW +: AW];
    regfile_read_port #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rp (
      .reset      (reset),
      .key        (k),
      .stored     (regs[k]),
      .stored_busy(busy[k]),
      .wa_en      (wa_ok),
      .wa_key     (wa_key),
      .wa_value   (wa_value),
      .wb_en      (wb_ok),
      .wb_key     (wb_key),
      .wb_value   (wb_value),
      .value      (rd_value[i*XLEN +: XLEN]),
      .busy       (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized-mix bench for regfile_scoreboard.
// Default-parameter instance plus a 4-port/16-reg/64-bit instance.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // default instance: XLEN 32, NREGS 32, NREAD 2
  logic [9:0]  d_rd_key;
  logic [63:0] d_rd_value;
  logic [1:0]  d_rd_busy;
  logic        d_wa_en, d_wb_en, d_iss_en;
  logic [4:0]  d_wa_key, d_wb_key, d_iss_key;
  logic [31:0] d_wa_value, d_wb_value;
  logic [5:0]  d_busy_count;

  regfile_scoreboard u_dut (
    .clk       (clk),
    .reset     (reset),
    .rd_key    (d_rd_key),
    .rd_value  (d_rd_value),
    .rd_busy   (d_rd_busy),
    .wa_en     (d_wa_en),
    .wa_key    (d_wa_key),
    .wa_value  (d_wa_value),
    .wb_en     (d_wb_en),
    .wb_key    (d_wb_key),
    .wb_value  (d_wb_value),
    .iss_en    (d_iss_en),
    .iss_key   (d_iss_key),
    .busy_count(d_busy_count)
  );

  // sweep instance: XLEN 64, NREGS 16, NREAD 4
  logic [15:0]  s_rd_key;
  logic [255:0] s_rd_value;
  logic [3:0]   s_rd_busy;
  logic         s_wa_en, s_wb_en, s_iss_en;
  logic [3:0]   s_wa_key, s_wb_key, s_iss_key;
  logic [63:0]  s_wa_value, s_wb_value;
  logic [4:0]   s_busy_count;

  regfile_scoreboard #(
    .XLEN (64),
    .NREGS(16),
    .NREAD(4)
  ) u_sweep (
    .clk       (clk),
    .reset     (reset),
    .rd_key    (s_rd_key),
    .rd_value  (s_rd_value),
    .rd_busy   (s_rd_busy),
    .wa_en     (s_wa_en),
    .wa_key    (s_wa_key),
    .wa_value  (s_wa_value),
    .wb_en     (s_wb_en),
    .wb_key    (s_wb_key),
    .wb_value  (s_wb_value),
    .iss_en    (s_iss_en),
    .iss_key   (s_iss_key),
    .busy_count(s_busy_count)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_wa_en = 0; d_wb_en = 0; d_iss_en = 0;
  endtask

  task automatic issue(input logic [4:0] k);
    d_iss_en = 1; d_iss_key = k;
    cyc();
    d_iss_en = 0;
  endtask

  // reference model for the sweep instance
  logic [63:0] m_mem [16];
  logic [15:0] m_busy;
  int          m_cnt;

  initial begin
    reset = 1;
    idle();
    d_wa_key = 0; d_wb_key = 0; d_iss_key = 0;
    d_wa_value = 0; d_wb_value = 0;
    d_rd_key = {5'd3, 5'd5};
    s_rd_key = 0;
    s_wa_en = 0; s_wb_en = 0; s_iss_en = 0;
    s_wa_key = 0; s_wb_key = 0; s_iss_key = 0;
    s_wa_value = 0; s_wb_value = 0;
    #2;
    check("rst_cnt", d_busy_count, 0);
    check("rst_val", d_rd_value, 0);
    check("rst_busy", d_rd_busy, 0);
    cyc();
    reset = 0;
    cyc();

    // write then read key 5
    d_wa_en = 1; d_wa_key = 5; d_wa_value = 32'hDEADBEEF;
    d_rd_key = {5'd0, 5'd5};
    #1 check("bypass_a", d_rd_value[31:0], 32'hDEADBEEF);
    cyc(); idle();
    #1 check("stored_5", d_rd_value[31:0], 32'hDEADBEEF);
    check("busy_5", d_rd_busy[0], 0);

    // write port conflict on key 7
    d_wa_en = 1; d_wa_key = 7; d_wa_value = 32'h11;
    d_wb_en = 1; d_wb_key = 7; d_wb_value = 32'h22;
    d_rd_key = {5'd7, 5'd7};
    #1 check("conf_byp", d_rd_value, {32'h11, 32'h11});
    cyc(); idle();
    #1 check("conf_st", d_rd_value, {32'h11, 32'h11});

    // port B alone, bypass then stored
    d_wb_en = 1; d_wb_key = 8; d_wb_value = 32'h22;
    d_rd_key = {5'd8, 5'd7};
    #1 check("byp_b", d_rd_value, {32'h22, 32'h11});
    cyc(); idle();
    #1 check("st_b", d_rd_value, {32'h22, 32'h11});

    // key 0 ignores writes and issues
    d_wa_en = 1; d_wa_key = 0; d_wa_value = 32'hFFFF;
    d_iss_en = 1; d_iss_key = 0;
    d_rd_key = {5'd0, 5'd0};
    #1 check("k0_byp", d_rd_value, 0);
    cyc(); idle();
    #1 check("k0_val", d_rd_value, 0);
    check("k0_busy", d_rd_busy, 0);
    check("k0_cnt", d_busy_count, 0);

    // scoreboard sequence
    issue(3); issue(4); issue(9);
    check("sb_cnt3", d_busy_count, 3);
    issue(9);
    check("sb_reiss", d_busy_count, 3);
    d_rd_key = {5'd4, 5'd3};
    #1 check("sb_busy", d_rd_busy, 2'b11);
    d_wa_en = 1; d_wa_key = 4; d_wa_value = 32'h44;
    #1 check("sb_wr_busy", d_rd_busy, 2'b01);
    check("sb_wr_val", d_rd_value[63:32], 32'h44);
    cyc(); idle();
    #1 check("sb_cnt2", d_busy_count, 2);
    d_wa_en = 1; d_wa_key = 3; d_wa_value = 32'h33;
    d_iss_en = 1; d_iss_key = 3;
    cyc(); idle();
    #1 check("sb_iw_cnt", d_busy_count, 2);
    check("sb_iw_busy", d_rd_busy, 2'b01);
    check("sb_iw_val", d_rd_value[31:0], 32'h33);
    d_wa_en = 1; d_wa_key = 3; d_wa_value = 32'h333;
    d_wb_en = 1; d_wb_key = 9; d_wb_value = 32'h999;
    cyc(); idle();
    #1 check("sb_cnt0", d_busy_count, 0);

    // mid-run reset with five pending registers
    for (int k = 1; k <= 5; k++) issue(5'(k));
    check("pre_rst_cnt", d_busy_count, 5);
    d_rd_key = {5'd1, 5'd5};
    #1 check("pre_rst_busy", d_rd_busy, 2'b11);
    #1 reset = 1;
    #1 check("mid_rst_cnt", d_busy_count, 0);
    check("mid_rst_val", d_rd_value, 0);
    check("mid_rst_busy", d_rd_busy, 0);
    d_wa_en = 1; d_wa_key = 6; d_wa_value = 32'h66;
    d_iss_en = 1; d_iss_key = 6;
    cyc(); idle();
    reset = 0;
    d_rd_key = {5'd6, 5'd5};
    #1 check("post_rst_a", d_rd_value, 0);
    check("post_rst_cnt", d_busy_count, 0);
    d_rd_key = {5'd8, 5'd7};
    #1 check("post_rst_b", d_rd_value, 0);
    issue(2);
    check("post_rst_op", d_busy_count, 1);

    // randomized mix on the sweep instance
    for (int k = 0; k < 16; k++) m_mem[k] = 0;
    m_busy = 0;
    m_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      logic [255:0] ev;
      logic [3:0]   eb;
      cyc();
      check("sw_cnt", s_busy_count, 5'(m_cnt));
      s_wa_en = 1'($urandom_range(0, 1));
      s_wb_en = 1'($urandom_range(0, 1));
      s_iss_en = 1'($urandom_range(0, 1));
      s_wa_key = 4'($urandom_range(0, 15));
      s_wb_key = 4'($urandom_range(0, 15));
      s_iss_key = 4'($urandom_range(0, 15));
      s_wa_value = {$urandom, $urandom};
      s_wb_value = {$urandom, $urandom};
      s_rd_key = 16'($urandom);
      ev = 0;
      eb = 0;
      for (int i = 0; i < 4; i++) begin
        logic [3:0] k;
        k = s_rd_key[i*4 +: 4];
        if (k == 0) begin
          ev[i*64 +: 64] = 0;
        end else if (s_wa_en && s_wa_key == k) begin
          ev[i*64 +: 64] = s_wa_value;
        end else if (s_wb_en && s_wb_key == k) begin
          ev[i*64 +: 64] = s_wb_value;
        end else begin
          ev[i*64 +: 64] = m_mem[k];
          eb[i] = m_busy[k];
        end
      end
      #1;
      check("sw_val", s_rd_value, ev);
      check("sw_busy", s_rd_busy, eb);
      if (s_wb_en && s_wb_key != 0) begin
        m_mem[s_wb_key] = s_wb_value;
        m_busy[s_wb_key] = 0;
      end
      if (s_wa_en && s_wa_key != 0) begin
        m_mem[s_wa_key] = s_wa_value;
        m_busy[s_wa_key] = 0;
      end
      if (s_iss_en && s_iss_key != 0) m_busy[s_iss_key] = 1;
      m_cnt = $countones(m_busy);
    end
    cyc();
    check("sw_cnt_end", s_busy_count, 5'(m_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
